matrix_scan_controller: RTL
===========================

MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 Parameter: DWELL_CYCLES, default 1000, clock cycles a column is driven per slot; legal range 1..65535.
REQ-002 Parameter: BLANK_CYCLES, default 4, clock cycles all outputs are dark before each column slot; legal range 1..255.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scan enable; low forces the display dark.
REQ-006 image_req  input  1  level request to change the displayed image; held high until image_ack.
REQ-007 image_sel  input  2  requested image index; stable while image_req is high.
REQ-008 image_ack  output  1  one-cycle pulse when the requested image is adopted.
REQ-009 col  output  3  one-hot column drive, active-high: col[2] drives outer columns 0 and 4, col[1] drives columns 1 and 3, col[0] drives center column 2 (mirrored image).
REQ-010 row  output  7  active-high row data for the currently driven column.
REQ-011 frame_start  output  1  one-cycle pulse at the start of each frame.

Function
REQ-012 FSM states: IDLE, BLANK, DRIVE; encoding from the shared package.
REQ-013 IDLE: col=0, row=0; enable=1 moves to BLANK with the column pointer at col[2] and pulses frame_start in that transition cycle.
REQ-014 BLANK: col=0, row=0 for exactly BLANK_CYCLES cycles, then DRIVE.
REQ-015 DRIVE: col = one-hot of the column pointer; row = pattern[active_image][pointer]; held for exactly DWELL_CYCLES cycles, then BLANK.
REQ-016 Column order: col[2] -> col[1] -> col[0] -> col[2]; pointer advances on the DRIVE->BLANK transition; wrap from col[0] to col[2] ends the frame.
REQ-017 Frame length: exactly 3*(BLANK_CYCLES+DWELL_CYCLES) cycles; frame_start pulses on the first BLANK cycle of col[2] in every frame.
REQ-018 col and row SHALL never be nonzero during BLANK or IDLE; col SHALL never have more than one bit set.
REQ-019 Image change only at a frame boundary: if image_req=1 in the cycle frame_start is asserted, active_image <= image_sel and image_ack pulses in that cycle; a mid-frame request waits for the next boundary.
REQ-020 A request still high after its ack is re-accepted at the next boundary with a new ack; requesters SHALL drop image_req the cycle after image_ack.
REQ-021 enable falling in any state: IDLE on the next edge, col=0 and row=0 from that edge, timer cleared, pointer reset to col[2], active_image retained, no ack issued.
REQ-022 enable rising with image_req=1: the request is accepted at the frame_start of the first frame.
REQ-023 Dwell and blank timer SHALL be 16 bits wide, count down, and be reloaded on every state entry; no wrap-around is possible within the legal parameter range.

Reset
REQ-024 reset_n=0 asynchronously forces: state=IDLE, pointer=col[2], timer=0, active_image=0, col=0, row=0, image_ack=0, frame_start=0.
REQ-025 Reset release takes effect on the first rising clock edge with reset_n=1; reset asserted mid-frame aborts the frame with no ack.

Structure
REQ-026 Package matrix_pkg SHALL hold the state encoding, column count (3), row width (7), and the 4x3 image pattern table: image 0 all 7'h00, image 3 all 7'h7F, images 1 and 2 the irrigation dry and wet icons.
REQ-027 One sub-module: scan_timer (loadable 16-bit down-counter with a terminal-count flag); the FSM, column pointer and image register remain in matrix_scan_controller.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2)
REQ-028 Reset, then enable=1 -> frame_start pulses once; col sequence 0,0,4,4,4,4,0,0,2,2,2,2,0,0,1,1,1,1 repeats with period 18.
REQ-029 image_req=1, image_sel=3 asserted mid-frame -> no row change until the next frame_start; image_ack coincides with frame_start; row=7'h7F in every DRIVE cycle afterward.
REQ-030 enable dropped during the col[1] DRIVE phase -> col=0, row=0 from the next edge; re-enable -> frame restarts at col[2] with frame_start.
REQ-031 reset_n pulsed low mid-DRIVE, asynchronous to clock -> all outputs 0 immediately; active_image returns to 0.
REQ-032 image_req held high for 3 frames -> exactly 3 image_ack pulses, each on a frame_start cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the 5x7 mirrored LED matrix scanner.
//   state_t      : scan FSM encoding (IDLE / BLANK / DRIVE)
//   NUM_COLS     : physical column groups driven (3, mirrored around center)
//   ROW_W        : row data width (7)
//   TMR_W        : dwell/blank timer width (16)
//   pattern_row(): 4x3 image table; slot 0 = outer cols, 2 = center col
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam int NUM_COLS = 3;
  localparam int ROW_W    = 7;
  localparam int TMR_W    = 16;

  // img 0: blank, img 1: dry icon, img 2: wet icon, img 3: all lit.
  function automatic logic [ROW_W-1:0] pattern_row(input logic [1:0] img,
                                                   input logic [1:0] slot);
    logic [ROW_W-1:0] r;
    r = '0;
    case (img)
      2'd1: case (slot)
              2'd0:    r = 7'h08;
              2'd1:    r = 7'h1C;
              2'd2:    r = 7'h3E;
              default: r = '0;
            endcase
      2'd2: case (slot)
              2'd0:    r = 7'h41;
              2'd1:    r = 7'h63;
              2'd2:    r = 7'h7F;
              default: r = '0;
            endcase
      2'd3:    r = (slot < 2'd3) ? 7'h7F : 7'h00;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter with terminal-count flag.
//   clock, reset_n : clock / async active-low reset (count clears to 0)
//   load, load_val : load takes priority over counting
//   count          : current value; holds at 0 (no wrap)
//   tc             : high while count == 0
module scan_timer
  import matrix_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         count <= '0;
    else if (load)        count <= load_val;
    else if (count != '0) count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: column-multiplexed scanner for a mirrored 5x7 matrix.
//   clock, reset_n        : clock / async active-low reset
//   enable                : scan enable, low forces dark + IDLE
//   image_req, image_sel  : level request for a new image, adopted at frame start
//   image_ack             : one-cycle pulse when the request is adopted
//   col[2:0]              : one-hot column drive (2 = outer, 1 = inner, 0 = center)
//   row[6:0]              : row data for the driven column
//   frame_start           : pulse on the first BLANK cycle of each frame
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             image_req,
  input  logic [1:0]       image_sel,
  output logic             image_ack,
  output logic [2:0]       col,
  output logic [ROW_W-1:0] row,
  output logic             frame_start
);

  localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK_CYCLES - 1);
  localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr;      // 0 = col[2], 1 = col[1], 2 = col[0]
  logic [1:0]       img;
  logic             tmr_load, tmr_tc;
  logic [TMR_W-1:0] tmr_val, tmr_cnt;

  scan_timer u_tmr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable)      state_nxt = ST_BLANK;
      ST_BLANK: if (!enable)     state_nxt = ST_IDLE;
                else if (tmr_tc) state_nxt = ST_DRIVE;
      ST_DRIVE: if (!enable)     state_nxt = ST_IDLE;
                else if (tmr_tc) state_nxt = ST_BLANK;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    col       = '0;
    row       = '0;
    // First BLANK cycle of slot 0 is the only cycle with a full blank count.
    frame_start = enable && (state == ST_BLANK) && (ptr == 2'd0) &&
                  (tmr_cnt == BLANK_LD);
    image_ack = frame_start && image_req;
    if (state == ST_DRIVE) begin
      col = 3'b100 >> ptr;
      row = pattern_row(img, ptr);
    end
    // Reload on every state change; IDLE keeps the timer parked at zero.
    tmr_load = (state_nxt != state) || (state == ST_IDLE);
    case (state_nxt)
      ST_BLANK: tmr_val = BLANK_LD;
      ST_DRIVE: tmr_val = DWELL_LD;
      default:  tmr_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      img <= '0;
    end else begin
      if (state_nxt == ST_IDLE)
        ptr <= '0;
      else if (state == ST_DRIVE && state_nxt == ST_BLANK)
        ptr <= (ptr == 2'd2) ? 2'd0 : 2'(ptr + 2'd1);
      if (image_ack) img <= image_sel;
    end
  end

endmodule
